// File: rtl/omsp_dma_pkg.sv
// Shared definitions for the openMSP430 DMA block-copy engine.
package omsp_dma_pkg;

    localparam int ADDR_W = 15;

    localparam logic [1:0] DMA_WE_WORD = 2'b11;
    localparam logic [1:0] DMA_WE_READ = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_FIN
    } dma_state_t;

endpackage

// File: rtl/omsp_dma_copier.sv
// Word-granular block-copy master for the openMSP430 DMA slave port.
// Reads one word, writes it back out, and repeats until the count runs out.
// Every output is registered from the next-state values, so nothing
// combinational leads from dma_ready to the port.
module omsp_dma_copier
    import omsp_dma_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              prio,
    input  logic              abort,
    input  logic              dma_ready,
    input  logic              dma_resp,
    input  logic [15:0]       dma_dout,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [15:0]       dma_din,
    output logic              dma_en,
    output logic [1:0]        dma_we,
    output logic              dma_priority,
    output logic              dma_wkup,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] src_nxt;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] dst_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [15:0]       data_buf;
    logic [15:0]       data_nxt;
    logic              prio_q;
    logic              prio_nxt;
    logic              err_nxt;

    // Next-state and working-register update; an error response outranks abort.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        cnt_nxt   = cnt_q;
        data_nxt  = data_buf;
        prio_nxt  = prio_q;
        err_nxt   = err;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_nxt  = 1'b0;
                    prio_nxt = prio;
                    if (word_cnt != '0) begin
                        src_nxt   = src_addr;
                        dst_nxt   = dst_addr;
                        cnt_nxt   = word_cnt;
                        state_nxt = ST_RD_REQ;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_RD_REQ: begin
                if (dma_ready && dma_resp) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (dma_ready) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                data_nxt = dma_dout;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (dma_ready && dma_resp) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    if (dma_ready) begin
                        src_nxt = src_q + ADDR_ONE;
                        dst_nxt = dst_q + ADDR_ONE;
                        cnt_nxt = cnt_q - CNT_ONE;
                    end
                    if (abort) begin
                        state_nxt = ST_IDLE;
                    end else if (dma_ready) begin
                        state_nxt = (cnt_q == CNT_ONE) ? ST_FIN : ST_RD_REQ;
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, working registers and port outputs, all derived from next-state values.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            data_buf     <= '0;
            prio_q       <= 1'b0;
            err          <= 1'b0;
            dma_en       <= 1'b0;
            dma_we       <= DMA_WE_READ;
            dma_addr     <= '0;
            dma_din      <= '0;
            dma_priority <= 1'b0;
            dma_wkup     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            src_q        <= src_nxt;
            dst_q        <= dst_nxt;
            cnt_q        <= cnt_nxt;
            data_buf     <= data_nxt;
            prio_q       <= prio_nxt;
            err          <= err_nxt;
            dma_en       <= (state_nxt == ST_RD_REQ) || (state_nxt == ST_WR_REQ);
            dma_we       <= (state_nxt == ST_WR_REQ) ? DMA_WE_WORD : DMA_WE_READ;
            dma_addr     <= (state_nxt == ST_WR_REQ) ? dst_nxt :
                            (state_nxt == ST_RD_REQ) ? src_nxt : '0;
            dma_din      <= (state_nxt == ST_WR_REQ) ? data_nxt : '0;
            dma_priority <= (state_nxt != ST_IDLE) && prio_nxt;
            dma_wkup     <= (state_nxt != ST_IDLE);
            busy         <= (state_nxt != ST_IDLE);
            done         <= (state_nxt == ST_FIN);
        end
    end

endmodule

// File: tb/tb_omsp_dma_copier.sv
// Directed testbench for omsp_dma_copier with a small memory/bus responder.
module tb_omsp_dma_copier;
    import omsp_dma_pkg::*;

    localparam int CNT_W = 8;

    logic              mclk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [14:0]       src_addr;
    logic [14:0]       dst_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic              prio;
    logic              abort;
    logic              dma_ready = 1'b0;
    logic              dma_resp = 1'b0;
    logic [15:0]       dma_dout = 16'h0000;
    logic [14:0]       dma_addr;
    logic [15:0]       dma_din;
    logic              dma_en;
    logic [1:0]        dma_we;
    logic              dma_priority;
    logic              dma_wkup;
    logic              busy;
    logic              done;
    logic              err;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [15:0] src_mem [0:32767];
    logic [14:0] wr_addr_log [0:255];
    logic [15:0] wr_data_log [0:255];
    int          wr_count     = 0;
    int          done_count   = 0;
    int          en_count     = 0;
    int          stall_checks = 0;
    int          stall_bad    = 0;
    logic        prev_stalled = 1'b0;
    logic [33:0] prev_req     = '0;

    int ready_mode    = 0;
    int stall_ctr     = 0;
    int resp_at_write = -1;
    int wr_base       = 0;

    omsp_dma_copier #(.CNT_W(CNT_W)) dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .word_cnt     (word_cnt),
        .prio         (prio),
        .abort        (abort),
        .dma_ready    (dma_ready),
        .dma_resp     (dma_resp),
        .dma_dout     (dma_dout),
        .dma_addr     (dma_addr),
        .dma_din      (dma_din),
        .dma_en       (dma_en),
        .dma_we       (dma_we),
        .dma_priority (dma_priority),
        .dma_wkup     (dma_wkup),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Free-running core clock.
    always #5 mclk = ~mclk;

    // Bus responder: serves reads, logs writes, counts events and watches for stall stability.
    always @(posedge mclk) begin
        if (dma_en) en_count <= en_count + 1;
        if (done) done_count <= done_count + 1;
        if (dma_en && dma_ready && !dma_resp) begin
            if (dma_we == DMA_WE_READ) begin
                dma_dout <= src_mem[dma_addr];
            end else begin
                wr_addr_log[wr_count[7:0]] <= dma_addr;
                wr_data_log[wr_count[7:0]] <= dma_din;
                wr_count <= wr_count + 1;
            end
        end
        if (prev_stalled) begin
            stall_checks <= stall_checks + 1;
            if ({dma_en, dma_we, dma_addr, dma_din} != prev_req) stall_bad <= stall_bad + 1;
        end
        prev_stalled <= dma_en && !dma_ready;
        prev_req     <= {dma_en, dma_we, dma_addr, dma_din};
    end

    // Handshake generator: ready tied high, or five wait cycles per request; optional error response.
    always @(negedge mclk) begin
        if (ready_mode == 0) begin
            dma_ready = 1'b1;
        end else if (dma_en) begin
            if (stall_ctr == 5) begin
                dma_ready = 1'b1;
                stall_ctr = 0;
            end else begin
                dma_ready = 1'b0;
                stall_ctr = stall_ctr + 1;
            end
        end else begin
            dma_ready = 1'b0;
            stall_ctr = 0;
        end
        dma_resp = (resp_at_write >= 0) && dma_en && (dma_we == DMA_WE_WORD) &&
                   ((wr_count - wr_base) == resp_at_write);
    end

    // Hard stop in case the sequence below ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] s, input logic [14:0] d,
                                 input logic [CNT_W-1:0] n, input logic p);
        src_addr = s;
        dst_addr = d;
        word_cnt = n;
        prio     = p;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    int cyc;
    int wb;
    int db;
    int eb;
    int sb;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        word_cnt = '0;
        prio     = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < 32768; i++) src_mem[i] = 16'h0000;
        for (int i = 0; i < 5; i++) src_mem[15'h0100 + i] = 16'hA001 + 16'(i);
        src_mem[15'h7FFF] = 16'hC001;
        src_mem[15'h0000] = 16'hC002;

        repeat (3) step();
        checkOutput("rst_dma_en", dma_en, 0);
        checkOutput("rst_dma_we", dma_we, 0);
        checkOutput("rst_dma_addr", dma_addr, 0);
        checkOutput("rst_dma_din", dma_din, 0);
        checkOutput("rst_dma_priority", dma_priority, 0);
        checkOutput("rst_dma_wkup", dma_wkup, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        reset_n = 1'b1;
        step();

        // Four-word copy with zero-wait handshake.
        wb = wr_count; db = done_count;
        applyStimulus(15'h0100, 15'h0200, 8'd4, 1'b1);
        checkOutput("t1_busy_rise", busy, 1);
        checkOutput("t1_first_en", dma_en, 1);
        checkOutput("t1_first_addr", dma_addr, 32'h0100);
        checkOutput("t1_first_we", dma_we, 0);
        checkOutput("t1_priority", dma_priority, 1);
        checkOutput("t1_wkup", dma_wkup, 1);
        waitDone(cyc);
        checkOutput("t1_done_cycle", cyc + 1, 13);
        checkOutput("t1_err", err, 0);
        checkOutput("t1_writes", wr_count - wb, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_wr_addr", wr_addr_log[wb + i], 32'h0200 + i);
            checkOutput("t1_wr_data", wr_data_log[wb + i], 32'hA001 + i);
        end
        step();
        checkOutput("t1_busy_fall", busy, 0);
        checkOutput("t1_done_pulse", done, 0);
        checkOutput("t1_done_count", done_count - db, 1);
        checkOutput("t1_priority_idle", dma_priority, 0);

        // Two-word copy with five stall cycles in every request phase.
        ready_mode = 1;
        wb = wr_count; db = done_count; sb = stall_checks;
        applyStimulus(15'h0100, 15'h0400, 8'd2, 1'b0);
        waitDone(cyc);
        checkOutput("t2_done_latency", cyc, 26);
        step();
        checkOutput("t2_done_count", done_count - db, 1);
        checkOutput("t2_stall_samples", stall_checks - sb, 20);
        checkOutput("t2_stall_stable", stall_bad, 0);
        checkOutput("t2_writes", wr_count - wb, 2);
        checkOutput("t2_wr_addr1", wr_addr_log[wb + 1], 32'h0401);
        checkOutput("t2_wr_data0", wr_data_log[wb], 32'hA001);
        checkOutput("t2_wr_data1", wr_data_log[wb + 1], 32'hA002);
        ready_mode = 0;
        step();

        // Source address wraps from 0x7FFF to 0x0000.
        wb = wr_count;
        applyStimulus(15'h7FFF, 15'h0010, 8'd2, 1'b0);
        checkOutput("t3_first_addr", dma_addr, 32'h7FFF);
        repeat (3) step();
        checkOutput("t3_second_rd_en", dma_en, 1);
        checkOutput("t3_second_rd_we", dma_we, 0);
        checkOutput("t3_second_rd_addr", dma_addr, 32'h0000);
        waitDone(cyc);
        checkOutput("t3_done_latency", cyc, 3);
        checkOutput("t3_wr_data0", wr_data_log[wb], 32'hC001);
        checkOutput("t3_wr_addr1", wr_addr_log[wb + 1], 32'h0011);
        checkOutput("t3_wr_data1", wr_data_log[wb + 1], 32'hC002);
        step();

        // Error response on the second write accept.
        wb = wr_count; db = done_count;
        wr_base = wr_count;
        resp_at_write = 1;
        applyStimulus(15'h0100, 15'h0280, 8'd3, 1'b0);
        repeat (5) step();
        checkOutput("t4_busy_before_resp", busy, 1);
        checkOutput("t4_wr_req_before_resp", dma_we, 32'h3);
        step();
        checkOutput("t4_busy_after_resp", busy, 0);
        checkOutput("t4_err_set", err, 1);
        checkOutput("t4_done_low", done, 0);
        resp_at_write = -1;
        repeat (3) step();
        checkOutput("t4_no_done", done_count - db, 0);
        checkOutput("t4_err_sticky", err, 1);
        checkOutput("t4_writes", wr_count - wb, 1);
        applyStimulus(15'h0100, 15'h0300, 8'd1, 1'b0);
        checkOutput("t4_err_cleared", err, 0);
        waitDone(cyc);
        checkOutput("t4_restart_latency", cyc, 3);
        step();

        // Abort during the third read request of a five-word copy.
        wb = wr_count; db = done_count;
        applyStimulus(15'h0100, 15'h0500, 8'd5, 1'b0);
        repeat (6) step();
        checkOutput("t5_third_rd_addr", dma_addr, 32'h0102);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("t5_busy_after_abort", busy, 0);
        checkOutput("t5_en_after_abort", dma_en, 0);
        repeat (3) step();
        checkOutput("t5_writes", wr_count - wb, 2);
        checkOutput("t5_no_done", done_count - db, 0);
        checkOutput("t5_err_unchanged", err, 0);
        checkOutput("t5_wr_data1", wr_data_log[wb + 1], 32'hA002);

        // Zero-length copy, with a start pulsed while it is still busy.
        eb = en_count; db = done_count;
        applyStimulus(15'h0100, 15'h0600, 8'd0, 1'b0);
        checkOutput("t6_zero_done", done, 1);
        checkOutput("t6_zero_busy", busy, 1);
        checkOutput("t6_zero_en", dma_en, 0);
        word_cnt = 8'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        checkOutput("t6_zero_busy_fall", busy, 0);
        checkOutput("t6_zero_done_fall", done, 0);
        repeat (4) step();
        checkOutput("t6_ignored_start_en", en_count - eb, 0);
        checkOutput("t6_ignored_start_busy", busy, 0);
        checkOutput("t6_zero_done_count", done_count - db, 1);

        // A start pulsed mid-copy must not disturb the copy in flight.
        wb = wr_count;
        applyStimulus(15'h0100, 15'h0600, 8'd2, 1'b0);
        step();
        src_addr = 15'h0700;
        dst_addr = 15'h0700;
        word_cnt = 8'd1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        waitDone(cyc);
        checkOutput("t6_midcopy_latency", cyc, 4);
        step();
        checkOutput("t6_midcopy_writes", wr_count - wb, 2);
        checkOutput("t6_midcopy_addr1", wr_addr_log[wb + 1], 32'h0601);
        checkOutput("t6_midcopy_data1", wr_data_log[wb + 1], 32'hA002);
        checkOutput("t6_final_stall_stable", stall_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/omsp_dma_copier.md
# omsp_dma_copier

Word-granular block-copy engine that drives the openMSP430 core's DMA slave port from outside the core, upstream of it. It reads N 16-bit words from a source word address and writes them to a destination word address through `dma_addr/dma_en/dma_we/dma_din`, consuming `dma_ready/dma_resp/dma_dout`. Firmware-side or testbench-side control logic programs it with a start pulse. It gives the team a self-contained DMA master for exercising the core's DMA arbitration and memory paths.

## Interface
- `CNT_W`, 8, width of the word-count input; max transfer is 2^CNT_W-1 words
- `mclk`  in  1  clock; same domain as the core's DMA port
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `src_addr`  in  15  source word address, latched on accepted start
- `dst_addr`  in  15  destination word address, latched on accepted start
- `word_cnt`  in  CNT_W  number of words, latched on accepted start
- `prio`  in  1  latched on start, driven on `dma_priority`
- `abort`  in  1  cancels an active copy
- `dma_ready`  in  1  core accepted the current request this cycle
- `dma_resp`  in  1  core flags an access error with `dma_ready`
- `dma_dout`  in  16  read data, valid the cycle after an accepted read
- `dma_addr`  out  15  word address of the current request
- `dma_din`  out  16  write data
- `dma_en`  out  1  request valid
- `dma_we`  out  2  byte write enables; `2'b11` for writes, `2'b00` for reads
- `dma_priority`  out  1  latched `prio` while busy, 0 otherwise
- `dma_wkup`  out  1  high while busy, so the core clocks run
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on successful completion
- `err`  out  1  sticky; set on `dma_resp`, cleared by the next accepted start

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
- IDLE with `start` and `word_cnt != 0`: latch the inputs, clear `err`, go to RD_REQ.
- IDLE with `start` and `word_cnt == 0`: go to FIN. No bus traffic.
- `start` outside IDLE is ignored.
- RD_REQ: `dma_en=1`, `dma_we=0`, `dma_addr=src`. Hold until `dma_ready`, then go to RD_WAIT.
- RD_WAIT: `dma_en=0`. Capture `dma_dout` into the data buffer, go to WR_REQ.
- WR_REQ: `dma_en=1`, `dma_we=2'b11`, `dma_addr=dst`, `dma_din=buffer`. Hold until `dma_ready`.
- On write accept: increment `src` and `dst` by 1 (15-bit wrap, 0x7FFF→0x0000) and decrement the remaining count. If the remaining count was 1, go to FIN; otherwise go to RD_REQ.
- FIN: assert `done` for one cycle, then go to IDLE.
- `dma_resp` high together with `dma_ready` in RD_REQ or WR_REQ: set `err`, go to IDLE, no `done`.
- `abort` in any busy state: go to IDLE next cycle, no `done`, `err` unchanged.
  - If `dma_ready` coincides with `abort`, that transfer completed on the bus; it is not retried.
- `abort` has priority over the normal transitions but not over `err` capture.
- Request outputs stay stable while `dma_en=1` and `dma_ready=0`.

## Timing
- Reset values: `dma_en=0`, `dma_we=0`, `dma_addr=0`, `dma_din=0`, `dma_priority=0`, `dma_wkup=0`, `busy=0`, `done=0`, `err=0`. State is IDLE.
- All outputs are registered or decoded from state/registers only. There is no combinational path from `dma_ready` to the outputs.
- Start to first `dma_en`: 1 cycle. `busy` rises on the same edge.
- Minimum 3 cycles per word with zero-wait `dma_ready`. An N-word copy takes 3N+1 cycles from start to `done`. `done` asserts the cycle after the last write accept.
- Zero-length copy: `done` asserts 1 cycle after `start`, `busy` high for that one cycle.

## Structure
- Package `omsp_dma_pkg`: state enum, `DMA_WE_WORD=2'b11`, `DMA_WE_READ=2'b00`, address width constant 15.
- Single module. No sub-module is needed; the address and count registers stay inline.

## Test plan
- Copy with `src=0x0100`, `dst=0x0200`, `word_cnt=4`, `dma_ready` tied 1, source holding 0xA001..0xA004 → destination equals the source, `done` at cycle 13 after start, `err=0`.
- `dma_ready` low for 5 cycles in each request phase → outputs held stable while stalled, data still correct, `done` once.
- `src=0x7FFF`, `word_cnt=2` → second read address is 0x0000.
- `dma_resp=1` on the 2nd write accept → `err=1`, no `done`, `busy` falls next cycle. A following start clears `err`.
- `abort` during the 3rd RD_REQ of a 5-word copy → IDLE next cycle, exactly 2 words written.
- `word_cnt=0` start, and `start` pulsed while busy → `done` 1 cycle after the zero-length start with no `dma_en`. The start pulsed while busy is ignored.
